// File: rtl/snooper_capture.sv
`default_nettype none
// ============================================================================
// Module   : snooper_capture
// Purpose  : Copies packets seen on a monitored stream into a packet memory.
// Revision : 1.0 - initial release
// ============================================================================
module snooper_capture #(
  parameter int SNOOP_FWD_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH           = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           mon_tdata,
  input  logic                            mon_tvalid,
  input  logic                            mon_tready,
  input  logic                            mon_tlast,
  output logic [SNOOP_FWD_ADDR_WIDTH-1:0] snooper_wr_addr,
  output logic [DATA_WIDTH-1:0]           snooper_wr_data,
  output logic                            snooper_wr_en,
  output logic                            snooper_done,
  input  logic                            ready_for_snooper,
  output logic [31:0]                     pkt_count,
  output logic [31:0]                     drop_count,
  output logic                            truncated
);

  localparam int AW = SNOOP_FWD_ADDR_WIDTH;
  localparam logic [AW-1:0] C_ADDR_MAX = '1;
  localparam logic [AW-1:0] C_ADDR_ONE = AW'(1);

  typedef enum logic [1:0] {
    START   = 2'd0,
    CAPTURE = 2'd1,
    SKIP    = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t                state_q, state_d, idle_d;
  logic [AW-1:0]         cur_addr_q, cur_addr_d;
  logic                  trunc_q, trunc_d;
  logic                  done_pend_q, done_pend_d;
  logic                  done_trunc_q, done_trunc_d;
  logic [1:0]            ho_cnt_q, ho_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  truncated_q, truncated_d;
  logic [31:0]           pkt_cnt_q, pkt_cnt_d;
  logic [31:0]           drop_cnt_q, drop_cnt_d;
  logic                  beat_w;
  logic                  holdoff_w;
  logic                  at_max_w;

  always_comb begin
    beat_w    = mon_tvalid && mon_tready;
    holdoff_w = done_q || (ho_cnt_q != 2'd0);
    at_max_w  = (cur_addr_q == C_ADDR_MAX);

    // Holdoff covers the done cycle plus two more; idle state reflects it one cycle ahead.
    done_d   = done_pend_q;
    ho_cnt_d = done_q ? 2'd2 : ((ho_cnt_q != 2'd0) ? ho_cnt_q - 2'd1 : 2'd0);
    idle_d   = (done_d || (ho_cnt_d != 2'd0)) ? HOLDOFF : START;

    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    trunc_d      = trunc_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_pend_d  = 1'b0;
    done_trunc_d = 1'b0;
    truncated_d  = done_pend_q ? done_trunc_q : truncated_q;
    pkt_cnt_d    = pkt_cnt_q + {31'd0, done_pend_q};
    drop_cnt_d   = drop_cnt_q;

    unique case (state_q)
      START, HOLDOFF: begin
        state_d = idle_d;
        if (beat_w) begin
          if (ready_for_snooper && (state_q == START) && !holdoff_w) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = '0;
            wr_data_d  = mon_tdata;
            cur_addr_d = '0;
            trunc_d    = 1'b0;
            if (mon_tlast) done_pend_d = 1'b1;
            else           state_d     = CAPTURE;
          end else begin
            drop_cnt_d = drop_cnt_q + 32'd1;
            if (!mon_tlast) state_d = SKIP;
          end
        end
      end
      CAPTURE: begin
        if (beat_w) begin
          if (at_max_w) begin
            trunc_d = 1'b1;
          end else begin
            wr_en_d    = 1'b1;
            wr_addr_d  = cur_addr_q + C_ADDR_ONE;
            wr_data_d  = mon_tdata;
            cur_addr_d = cur_addr_q + C_ADDR_ONE;
          end
          if (mon_tlast) begin
            done_pend_d  = 1'b1;
            done_trunc_d = trunc_q || at_max_w;
            state_d      = idle_d;
          end
        end
      end
      SKIP: begin
        if (beat_w && mon_tlast) state_d = idle_d;
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= START;
      cur_addr_q   <= '0;
      trunc_q      <= 1'b0;
      done_pend_q  <= 1'b0;
      done_trunc_q <= 1'b0;
      ho_cnt_q     <= 2'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      done_q       <= 1'b0;
      truncated_q  <= 1'b0;
      pkt_cnt_q    <= 32'd0;
      drop_cnt_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      trunc_q      <= trunc_d;
      done_pend_q  <= done_pend_d;
      done_trunc_q <= done_trunc_d;
      ho_cnt_q     <= ho_cnt_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      done_q       <= done_d;
      truncated_q  <= truncated_d;
      pkt_cnt_q    <= pkt_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign snooper_wr_en   = wr_en_q;
  assign snooper_wr_addr = wr_addr_q;
  assign snooper_wr_data = wr_data_q;
  assign snooper_done    = done_q;
  assign truncated       = truncated_q;
  assign pkt_count       = pkt_cnt_q;
  assign drop_count      = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_snooper_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_snooper_capture
// Purpose  : Bench for snooper_capture with a cycle-scheduled reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_snooper_capture;

  localparam int AW    = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 16;
  localparam int NC    = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] mon_tdata = '0;
  logic          mon_tvalid = 1'b0;
  logic          mon_tready = 1'b0;
  logic          mon_tlast = 1'b0;
  logic          ready_for_snooper = 1'b0;
  logic [AW-1:0] snooper_wr_addr;
  logic [DW-1:0] snooper_wr_data;
  logic          snooper_wr_en;
  logic          snooper_done;
  logic [31:0]   pkt_count;
  logic [31:0]   drop_count;
  logic          truncated;

  always #5 clk = ~clk;

  snooper_capture #(.SNOOP_FWD_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .mon_tdata(mon_tdata), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast),
    .snooper_wr_addr(snooper_wr_addr), .snooper_wr_data(snooper_wr_data),
    .snooper_wr_en(snooper_wr_en), .snooper_done(snooper_done),
    .ready_for_snooper(ready_for_snooper),
    .pkt_count(pkt_count), .drop_count(drop_count), .truncated(truncated)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Events the model schedules, indexed by the cycle in which they must be visible.
  bit            sch_wr[NC];
  logic [AW-1:0] sch_addr[NC];
  logic [DW-1:0] sch_data[NC];
  bit            sch_done[NC];
  bit            sch_tr[NC];
  int            sch_drop[NC];
  bit            rst_eff[NC];

  int m_mode = 0;   // 0 waiting for first beat, 1 capturing, 2 skipping
  int m_idx = 0;
  bit m_over = 1'b0;
  int rst_cyc = -100;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit in_holdoff(input int c);
    bit h = 1'b0;
    for (int d = c - 2; d <= c; d++)
      if (d >= 0 && d > rst_cyc && sch_done[d]) h = 1'b1;
    return h;
  endfunction

  always @(posedge clk) begin
    if (cyc + 3 < NC) begin
      if (rst) begin
        rst_eff[cyc+1]  = 1'b1;
        sch_done[cyc+1] = 1'b0;
        rst_cyc = cyc;
        m_mode = 0;
        m_idx = 0;
        m_over = 1'b0;
      end else if (mon_tvalid && mon_tready) begin
        case (m_mode)
          0: begin
            if (ready_for_snooper && !in_holdoff(cyc)) begin
              sch_wr[cyc+1] = 1'b1; sch_addr[cyc+1] = '0; sch_data[cyc+1] = mon_tdata;
              if (mon_tlast) begin
                sch_done[cyc+2] = 1'b1; sch_tr[cyc+2] = 1'b0;
              end else begin
                m_mode = 1; m_idx = 1; m_over = 1'b0;
              end
            end else begin
              sch_drop[cyc+1]++;
              if (!mon_tlast) m_mode = 2;
            end
          end
          1: begin
            if (m_idx < DEPTH) begin
              sch_wr[cyc+1] = 1'b1; sch_addr[cyc+1] = AW'(m_idx); sch_data[cyc+1] = mon_tdata;
              m_idx++;
            end else begin
              m_over = 1'b1;
            end
            if (mon_tlast) begin
              sch_done[cyc+2] = 1'b1; sch_tr[cyc+2] = m_over;
              m_mode = 0;
            end
          end
          default: if (mon_tlast) m_mode = 0;
        endcase
      end
    end
    cyc = cyc + 1;
  end

  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_data = '0;
  logic [31:0]   e_pkt = '0;
  logic [31:0]   e_drop = '0;
  bit            e_tr = 1'b0;
  bit            started = 1'b0;
  int            wr_seen = 0;
  int            done_seen = 0;
  int            last_done_cyc = 0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clk) begin
    if (cyc < NC) begin
      if (rst_eff[cyc]) begin
        started = 1'b1;
        e_addr = '0; e_data = '0; e_pkt = '0; e_drop = '0; e_tr = 1'b0;
      end else if (started) begin
        if (sch_done[cyc]) begin
          e_pkt = e_pkt + 32'd1;
          e_tr  = sch_tr[cyc];
        end
        e_drop = e_drop + 32'(sch_drop[cyc]);
        if (sch_wr[cyc]) begin
          e_addr = sch_addr[cyc];
          e_data = sch_data[cyc];
        end
      end
      if (started) begin
        chk("wr_en",     64'(snooper_wr_en),   64'(sch_wr[cyc] && !rst_eff[cyc]));
        chk("wr_addr",   64'(snooper_wr_addr), 64'(e_addr));
        chk("wr_data",   snooper_wr_data,      e_data);
        chk("done",      64'(snooper_done),    64'(sch_done[cyc] && !rst_eff[cyc]));
        chk("pkt_count", 64'(pkt_count),       64'(e_pkt));
        chk("drop_count",64'(drop_count),      64'(e_drop));
        chk("truncated", 64'(truncated),       64'(e_tr));
        if (snooper_wr_en) begin wr_seen++; last_addr = snooper_wr_addr; end
        if (snooper_done) begin done_seen++; last_done_cyc = cyc; end
      end
    end
  end

  task automatic drive(input bit v, input bit tr, input bit l, input bit rdy, input logic [DW-1:0] d);
    mon_tvalid = v; mon_tready = tr; mon_tlast = l; ready_for_snooper = rdy; mon_tdata = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b1, 1'b0, 1'b1, {$urandom, $urandom});
  endtask

  task automatic pkt(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      drive(1'b1, 1'b1, i == n - 1, rdy, {32'hD000_0000 + 32'(i), $urandom});
  endtask

  task automatic do_reset;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(3);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, first;
    @(negedge clk);
    do_reset;
    chk("reset_pkt", 64'(pkt_count), 64'd0);
    chk("reset_wr_en", 64'(snooper_wr_en), 64'd0);

    // Four-beat capture and its latency
    w0 = wr_seen; first = cyc;
    pkt(4, 1'b1);
    idle(8);
    chk("s1_writes", 64'(wr_seen - w0), 64'd4);
    chk("s1_last_addr", 64'(last_addr), 64'd3);
    chk("s1_done_latency", 64'(last_done_cyc - first), 64'd5);
    chk("s1_pkt", 64'(pkt_count), 64'd1);
    chk("s1_model_pkt", 64'(e_pkt), 64'd1);

    // Memory not ready: whole packet dropped, next one captured
    do_reset;
    w0 = wr_seen; d0 = done_seen;
    pkt(3, 1'b0);
    idle(6);
    chk("s2_writes", 64'(wr_seen - w0), 64'd0);
    chk("s2_done", 64'(done_seen - d0), 64'd0);
    chk("s2_drop", 64'(drop_count), 64'd1);
    pkt(2, 1'b1);
    idle(6);
    chk("s2_pkt", 64'(pkt_count), 64'd1);
    chk("s2_writes2", 64'(wr_seen - w0), 64'd2);

    // Truncation at depth 16, cleared by the next packet
    do_reset;
    w0 = wr_seen;
    pkt(20, 1'b1);
    idle(6);
    chk("s3_writes", 64'(wr_seen - w0), 64'd16);
    chk("s3_last_addr", 64'(last_addr), 64'd15);
    chk("s3_truncated", 64'(truncated), 64'd1);
    chk("s3_model_tr", 64'(e_tr), 64'd1);
    pkt(3, 1'b1);
    idle(6);
    chk("s3_truncated_clr", 64'(truncated), 64'd0);
    chk("s3_pkt", 64'(pkt_count), 64'd2);

    // Exactly-full packet is not truncated
    do_reset;
    pkt(16, 1'b1);
    idle(6);
    chk("s3b_truncated", 64'(truncated), 64'd0);
    chk("s3b_last_addr", 64'(last_addr), 64'd15);

    // Holdoff: packet starting one cycle after done is dropped
    do_reset;
    w0 = wr_seen;
    pkt(1, 1'b1);
    idle(2);
    pkt(3, 1'b1);
    idle(6);
    chk("s4_drop", 64'(drop_count), 64'd1);
    chk("s4_pkt", 64'(pkt_count), 64'd1);
    chk("s4_writes", 64'(wr_seen - w0), 64'd1);

    // Stalled link mid-packet
    do_reset;
    w0 = wr_seen;
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b1, 64'hA0 + 64'(i));
    repeat (5) drive(1'b1, 1'b0, 1'b0, 1'b1, {$urandom, $urandom});
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'hA3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'hA4);
    idle(6);
    chk("s5_writes", 64'(wr_seen - w0), 64'd5);
    chk("s5_last_addr", 64'(last_addr), 64'd4);
    chk("s5_last_data", snooper_wr_data, 64'hA4);

    // Reset in the middle of a packet
    do_reset;
    d0 = done_seen;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'hB0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'hB1);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h0);
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'hB2);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 64'hB3);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 64'hB4);
    idle(6);
    chk("s6_done", 64'(done_seen - d0), 64'd1);
    chk("s6_pkt", 64'(pkt_count), 64'd1);
    chk("s6_last_addr", 64'(last_addr), 64'd2);
    chk("s6_last_data", snooper_wr_data, 64'hB4);

    // Randomized traffic against the model
    do_reset;
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0, {$urandom, $urandom});
    end
    rst = 1'b0;
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/snooper_capture.md
SNOOPER_CAPTURE -- requirements
Module: snooper_capture

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter SNOOP_FWD_ADDR_WIDTH, default 9: packet-memory beat address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: beat width; equals the packet-memory write width.
Ports (name, direction, width, meaning):
REQ-003 SHALL have clk, input, 1: the single clock; all logic on the rising edge.
REQ-004 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have mon_tdata, input, DATA_WIDTH: monitored stream data.
REQ-006 SHALL have mon_tvalid and mon_tready, inputs, 1 each: monitored link handshake, observed only and never driven.
REQ-007 SHALL have mon_tlast, input, 1: last beat of the monitored packet.
REQ-008 SHALL have snooper_wr_addr, output, SNOOP_FWD_ADDR_WIDTH: packet-memory beat address.
REQ-009 SHALL have snooper_wr_data, output, DATA_WIDTH: packet-memory write data.
REQ-010 SHALL have snooper_wr_en, output, 1: packet-memory write strobe.
REQ-011 SHALL have snooper_done, output, 1: one-cycle pulse marking the end of a captured packet.
REQ-012 SHALL have ready_for_snooper, input, 1: packet memory can accept a new packet.
REQ-013 SHALL have pkt_count and drop_count, outputs, 32 each: count of captured packets and dropped packets.
REQ-014 SHALL have truncated, output, 1: the last captured packet exceeded the memory depth.

Function
REQ-015 SHALL define a beat as any cycle with mon_tvalid && mon_tready; no other cycle has effect.
REQ-016 SHALL implement states START, CAPTURE, SKIP and HOLDOFF.
REQ-017 In START, a beat with ready_for_snooper=1 and holdoff clear SHALL be written at address 0 and the state SHALL go to CAPTURE; with mon_tlast=1 on that beat, the state SHALL stay in START and the packet SHALL complete.
REQ-018 In START, a beat with ready_for_snooper=0 SHALL increment drop_count and move to SKIP, or stay in START when mon_tlast=1.
REQ-019 In CAPTURE, each beat SHALL be written at the previous address plus 1.
REQ-020 In CAPTURE, a beat with mon_tlast=1 SHALL complete the packet and return the state to START.
REQ-021 In SKIP, no writes SHALL occur; a beat with mon_tlast=1 SHALL return the state to START.
REQ-022 Write outputs SHALL be registered: a beat accepted in cycle N SHALL give snooper_wr_en=1 with address and data in cycle N+1.
REQ-023 snooper_wr_en SHALL be 0 in every cycle without a write; snooper_wr_addr and snooper_wr_data SHALL hold their last values when snooper_wr_en=0.
REQ-024 For a completing beat in cycle N, snooper_done SHALL pulse for exactly one cycle in N+2, one cycle after the final write.
REQ-025 pkt_count SHALL increment in the same cycle as snooper_done.
REQ-026 Truncation: once address 2^SNOOP_FWD_ADDR_WIDTH-1 is written, further beats SHALL NOT be written and the address SHALL NOT wrap.
REQ-027 A truncated packet SHALL still end with snooper_done at its tlast; truncated SHALL be set at that done and cleared at the next done.
REQ-028 ready_for_snooper SHALL be sampled only on the first beat of a packet; deassertion mid-packet SHALL NOT affect capture.
REQ-029 Holdoff: for the cycle snooper_done is asserted and the following 2 cycles, ready_for_snooper SHALL be treated as 0.
REQ-030 A first beat arriving during holdoff SHALL be dropped per REQ-018.
REQ-031 pkt_count and drop_count SHALL wrap modulo 2^32.
REQ-032 A single-beat packet SHALL give one write at address 0 followed by snooper_done.

Reset
REQ-033 While rst=1: state=START, holdoff clear, snooper_wr_en=0, snooper_done=0, snooper_wr_addr=0, snooper_wr_data=0, counts=0, truncated=0.
REQ-034 Reset mid-packet SHALL abandon the packet without a snooper_done pulse; the remaining beats of that packet after reset SHALL be treated as a new packet.

Verification
REQ-035 Ready memory, 4-beat packet D0..D3 in cycles 10..13 -> wr_en cycles 11..14 at addr 0..3 with D0..D3; done at cycle 15; pkt_count=1.
REQ-036 ready_for_snooper=0, 3-beat packet -> no wr_en, no done, drop_count=1; next packet with ready=1 captured normally.
REQ-037 Width 4 (depth 16), 20-beat packet -> 16 writes at addr 0..15, done after the tlast beat, truncated=1; next normal packet clears truncated.
REQ-038 Single-beat packet, then a packet starting 1 cycle after done -> second packet dropped by holdoff, drop_count=1.
REQ-039 mon_tvalid=1 with mon_tready=0 for 5 cycles mid-packet -> no writes in those cycles; address continues contiguously afterwards.
REQ-040 rst pulsed after beat 2 of a 5-beat packet -> no done; beats 3..5 captured at addr 0..2 with done.
